oam_dma: RTL and testbench
==========================

Name: oam_dma

Overview:
- CPU-side OAM DMA engine for $4014; it is the writer that feeds SpriteRAM's oam_load/data_in port.
- On a page write it halts the CPU, reads 256 bytes from {page, 8'h00}..{page, 8'hFF} on get cycles, and writes each byte into OAM on the following put cycle.
- It sits between the CPU bus arbiter and SpriteRAM and shares the SpriteRAM ce.
- SpriteRAM auto-increments oam_ptr per load, so the engine carries no OAM address.

Parameters:
- NUM_BYTES, 256, bytes per transfer. Power of two, at most 256. The counter is 8-bit, and the transfer ends when the low log2(NUM_BYTES) bits wrap.

Ports:
- clk  in  1  system clock
- i_rst  in  1  asynchronous active-low reset
- ce  in  1  CPU-cycle enable; all state advances only when ce=1
- i_reg_wr  in  1  CPU write strobe to $4014, qualified by ce
- i_reg_data  in  8  source page written to $4014
- i_cpu_read  in  1  the current CPU cycle is a read cycle; halt takes effect only on a read
- o_cpu_halt  out  1  RDY low request to CPU; 1 = CPU stalled
- o_addr  out  16  DMA source address {page, cnt}
- o_mem_rd  out  1  DMA owns bus and reads o_addr this cycle
- i_mem_data  in  8  read data, valid in the same cycle as o_mem_rd
- o_oam_load  out  1  connects to SpriteRAM oam_load
- o_oam_data  out  8  connects to SpriteRAM data_in
- o_busy  out  1  1 in any state other than IDLE
- o_done  out  1  one-clk pulse after the final OAM write

Behaviour:
Reset (i_rst=0, async):
- state=IDLE, ph=0, page=0, cnt=0, latch=0.
- All outputs 0, including o_cpu_halt, which is released immediately.
- Reset mid-transfer abandons the transfer. OAM keeps the bytes already written.

Phase:
- ph toggles on every ce. ph=0 is a get cycle and ph=1 is a put cycle.
- ph runs free, including in IDLE.

States (transitions on clk edges with ce=1):
- IDLE
  - If i_reg_wr: page<=i_reg_data, cnt<=0, go to HALT.
- HALT
  - o_cpu_halt=1.
  - If i_cpu_read, this is the dummy cycle. If ph=1, go to READ; else go to ALIGN.
  - If !i_cpu_read, stay in HALT.
- ALIGN
  - o_cpu_halt=1; one alignment cycle, always on ph=1.
  - Next state is READ.
- READ
  - o_cpu_halt=1, o_mem_rd=1, o_addr={page,cnt}, always on ph=0.
  - latch<=i_mem_data; next state is WRITE.
- WRITE
  - o_cpu_halt=1, o_oam_load=1, o_oam_data=latch, always on ph=1.
  - cnt<=cnt+1.
  - If cnt==NUM_BYTES-1, go to DONE; else go to READ.
- DONE
  - o_done=1 for one clk and o_cpu_halt=0.
  - Then IDLE unconditionally, without waiting for ce.

Output decoding:
- Outputs are decoded from registered state; there is no combinational path from inputs to outputs.
- Exceptions: o_oam_data comes from latch, and o_addr from page/cnt.

Timing:
- Stalled CPU cycles, counted from the first halt-with-read cycle to the last write, are 513 if the HALT cycle is ph=1 and 514 if it is ph=0.

Boundary conditions:
- i_reg_wr while o_busy=1: ignored; page is unchanged.
- i_reg_wr with ce=0: ignored.
- ce=0 in any state: everything freezes, including ph. o_oam_load may stay high, but SpriteRAM qualifies it with ce, so no extra write occurs.
- i_mem_data is sampled only in READ with ce=1.
- page=$FF: the address runs $FF00..$FFFF with no carry out. cnt wraps to 0 after $FF.
- DONE lasts exactly one clk, so a back-to-back $4014 write is accepted on the next ce in IDLE.

Decomposition:
- ppu_pkg holds:
  - typedef enum logic [2:0] dma_state_t {IDLE, HALT, ALIGN, READ, WRITE, DONE}
  - localparam DMA_REG_ADDR = 16'h4014
  - localparam OAM_BYTES = 256
- There is no sub-module. The phase toggle and counter are inline; expected size is about 150 lines.

Test Plan:
1. Write $02 with ce every clk, HALT entered at ph=1 -> 256 reads $0200..$02FF. Each o_oam_load carries the byte from the preceding read. o_cpu_halt high for exactly 513 ce cycles; o_done pulses once.
2. Same as 1 but HALT at ph=0 -> exactly one ALIGN cycle; 514 stalled cycles; every READ on ph=0 and every WRITE on ph=1.
3. i_cpu_read held low for 3 cycles after the write -> stay in HALT with o_mem_rd=0 for those cycles, then normal transfer.
4. ce pulsed every 3rd clk, page $FF -> addresses $FF00..$FFFF. Exactly 256 ce-qualified oam_load strobes; SpriteRAM OAM matches the source memory pattern.
5. Second $4014 write ($05) at transfer byte 100 -> ignored; all 256 reads stay on the original page.
6. i_rst asserted at byte 37 -> o_cpu_halt=0 and o_busy=0 without waiting for a clock edge. After release, a fresh write of $03 transfers all 256 bytes from $0300.

Source files
------------

// File: rtl/ppu_pkg.sv
// Shared PPU-side definitions: OAM DMA state encoding, $4014 register address
// and the size of sprite OAM.
package ppu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE,
    DONE
  } dma_state_t;

  localparam logic [15:0] DMA_REG_ADDR = 16'h4014;
  localparam int          OAM_BYTES    = 256;

endpackage

// File: rtl/oam_dma.sv
// CPU-side OAM DMA engine behind $4014: stalls the CPU, copies one page of
// memory into SpriteRAM through its auto-incrementing oam_load port.
module oam_dma
  import ppu_pkg::*;
#(
  parameter int NUM_BYTES = OAM_BYTES
) (
  input  logic        clk,
  input  logic        i_rst,
  input  logic        ce,
  input  logic        i_reg_wr,
  input  logic [7:0]  i_reg_data,
  input  logic        i_cpu_read,
  output logic        o_cpu_halt,
  output logic [15:0] o_addr,
  output logic        o_mem_rd,
  input  logic [7:0]  i_mem_data,
  output logic        o_oam_load,
  output logic [7:0]  o_oam_data,
  output logic        o_busy,
  output logic        o_done
);

  // Only the low log2(NUM_BYTES) counter bits decide the end of a transfer.
  localparam logic [7:0] LAST_IDX = 8'(NUM_BYTES - 1);

  dma_state_t state_q, state_d;
  logic       ph_q;
  logic [7:0] page_q, page_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] latch_q, latch_d;

  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
      ph_q    <= 1'b0;
      page_q  <= 8'h00;
      cnt_q   <= 8'h00;
      latch_q <= 8'h00;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      cnt_q   <= cnt_d;
      latch_q <= latch_d;
      if (ce) begin
        ph_q <= ~ph_q;
      end
    end
  end

  // DONE leaves on the very next clock, ce or not, so a new write is never lost.
  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    cnt_d   = cnt_q;
    latch_d = latch_q;
    case (state_q)
      IDLE: begin
        if (ce && i_reg_wr) begin
          page_d  = i_reg_data;
          cnt_d   = 8'h00;
          state_d = HALT;
        end
      end
      HALT: begin
        if (ce && i_cpu_read) begin
          state_d = ph_q ? READ : ALIGN;
        end
      end
      ALIGN: begin
        if (ce) begin
          state_d = READ;
        end
      end
      READ: begin
        if (ce) begin
          latch_d = i_mem_data;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (ce) begin
          cnt_d   = cnt_q + 8'h01;
          state_d = ((cnt_q & LAST_IDX) == LAST_IDX) ? DONE : READ;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    o_cpu_halt = 1'b0;
    o_mem_rd   = 1'b0;
    o_oam_load = 1'b0;
    o_busy     = 1'b1;
    o_done     = 1'b0;
    case (state_q)
      IDLE: begin
        o_busy = 1'b0;
      end
      HALT, ALIGN: begin
        o_cpu_halt = 1'b1;
      end
      READ: begin
        o_cpu_halt = 1'b1;
        o_mem_rd   = 1'b1;
      end
      WRITE: begin
        o_cpu_halt = 1'b1;
        o_oam_load = 1'b1;
      end
      DONE: begin
        o_done = 1'b1;
      end
      default: begin
        o_busy = 1'b0;
      end
    endcase
  end

  assign o_addr     = {page_q, cnt_q};
  assign o_oam_data = latch_q;

endmodule

// File: tb/tb_oam_dma.sv
// Randomized scoreboard bench for oam_dma: a stimulus process queues the
// expected reads/OAM bytes of each accepted transfer, a negedge monitor checks them.
module tb_oam_dma;

  logic        clk;
  logic        rst_n;
  logic        ce;
  logic        i_reg_wr;
  logic [7:0]  i_reg_data;
  logic        i_cpu_read;
  logic        o_cpu_halt;
  logic [15:0] o_addr;
  logic        o_mem_rd;
  logic [7:0]  i_mem_data;
  logic        o_oam_load;
  logic [7:0]  o_oam_data;
  logic        o_busy;
  logic        o_done;

  logic [7:0]  mem [0:65535];
  logic [7:0]  oam [0:255];
  logic [15:0] expAddr [$];
  logic [7:0]  expData [$];

  int   checks = 0;
  int   fails = 0;
  int   loadCnt = 0;
  int   doneCnt = 0;
  int   stallCnt = 0;
  int   expStall = 0;
  bit   stallStarted = 0;
  logic tbPh;

  int   cePeriod = 1;
  int   ceCnt = 0;
  int   readLowLeft = 0;
  bit   pendingWr = 0;
  int   wantWrPh = -1;

  oam_dma dut (
    .clk        (clk),
    .i_rst      (rst_n),
    .ce         (ce),
    .i_reg_wr   (i_reg_wr),
    .i_reg_data (i_reg_data),
    .i_cpu_read (i_cpu_read),
    .o_cpu_halt (o_cpu_halt),
    .o_addr     (o_addr),
    .o_mem_rd   (o_mem_rd),
    .i_mem_data (i_mem_data),
    .o_oam_load (o_oam_load),
    .o_oam_data (o_oam_data),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  assign i_mem_data = mem[o_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Phase seen by the CPU: toggles once per enabled cycle since reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tbPh <= 1'b0;
    else if (ce) tbPh <= ~tbPh;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: sample mid-cycle, compare every ce-qualified read/load against the queues.
  always @(negedge clk) begin
    if (!rst_n) begin
      stallStarted = 0;
      stallCnt = 0;
    end else begin
      if (ce && o_cpu_halt) begin
        if (!stallStarted && i_cpu_read) begin
          stallStarted = 1;
          expStall = tbPh ? 513 : 514;
        end
        if (stallStarted) stallCnt++;
        else checkOutput("wait_no_read", int'(o_mem_rd), 0);
      end
      if (ce && o_mem_rd) begin
        checkOutput("read_phase", int'(tbPh), 0);
        if (expAddr.size() == 0) checkOutput("unexpected_read", 1, 0);
        else checkOutput("read_addr", int'(o_addr), int'(expAddr.pop_front()));
      end
      if (ce && o_oam_load) begin
        checkOutput("write_phase", int'(tbPh), 1);
        if (expData.size() == 0) checkOutput("unexpected_load", 1, 0);
        else checkOutput("oam_data", int'(o_oam_data), int'(expData.pop_front()));
        oam[loadCnt % 256] = o_oam_data;
        loadCnt++;
      end
      if (o_done) begin
        doneCnt++;
        checkOutput("stall_cycles", stallCnt, expStall);
        checkOutput("reads_left_at_done", expAddr.size(), 0);
        checkOutput("loads_left_at_done", expData.size(), 0);
        stallStarted = 0;
        stallCnt = 0;
      end
    end
  end

  task automatic applyStimulus();
    @(posedge clk);
    #1;
    ceCnt++;
    ce = (ceCnt % cePeriod) == 0;
    i_reg_wr = 1'b0;
    i_cpu_read = 1'b1;
    if (ce && readLowLeft > 0) begin
      i_cpu_read = 1'b0;
      readLowLeft--;
    end
    if (pendingWr && ce && (wantWrPh < 0 || int'(tbPh) == wantWrPh)) begin
      i_reg_wr = 1'b1;
      pendingWr = 0;
    end
  endtask

  task automatic issueWrite(input logic [7:0] page, input int wantHaltPh,
                            input int readLow, input bit accept);
    int n = 0;
    i_reg_data = page;
    wantWrPh = (wantHaltPh < 0) ? -1 : 1 - wantHaltPh;
    pendingWr = 1;
    while (pendingWr && n < 50) begin
      applyStimulus();
      n++;
    end
    if (pendingWr) begin
      checkOutput("write_issue_timeout", 1, 0);
      pendingWr = 0;
    end
    readLowLeft = readLow;
    if (accept) begin
      for (int i = 0; i < 256; i++) begin
        expAddr.push_back({page, 8'(i)});
        expData.push_back(mem[{page, 8'(i)}]);
      end
    end
  endtask

  task automatic waitDone(input int budget);
    int start = doneCnt;
    int n = 0;
    while (doneCnt == start && n < budget) begin
      applyStimulus();
      n++;
    end
    if (doneCnt == start) checkOutput("done_timeout", 1, 0);
    repeat (4) applyStimulus();
    checkOutput("done_pulses", doneCnt - start, 1);
    checkOutput("idle_after_done", int'(o_busy), 0);
  endtask

  task automatic waitLoads(input int base, input int count);
    int n = 0;
    while (loadCnt - base < count && n < 5000) begin
      applyStimulus();
      n++;
    end
    if (loadCnt - base < count) checkOutput("load_wait_timeout", 1, 0);
  endtask

  task automatic runTransfer(input logic [7:0] page, input int wantHaltPh,
                             input int readLow, input int cePer);
    cePeriod = cePer;
    issueWrite(page, wantHaltPh, readLow, 1);
    waitDone(600 * cePer + 50);
  endtask

  initial begin
    int base;
    int bad;
    rst_n = 1'b0;
    ce = 1'b0;
    i_reg_wr = 1'b0;
    i_reg_data = 8'h00;
    i_cpu_read = 1'b1;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) oam[i] = 8'h00;

    #3;
    checkOutput("rst_halt", int'(o_cpu_halt), 0);
    checkOutput("rst_busy", int'(o_busy), 0);
    checkOutput("rst_done", int'(o_done), 0);
    checkOutput("rst_mem_rd", int'(o_mem_rd), 0);
    checkOutput("rst_oam_load", int'(o_oam_load), 0);
    checkOutput("rst_addr", int'(o_addr), 0);
    checkOutput("rst_oam_data", int'(o_oam_data), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // A $4014 strobe without ce must not start anything.
    @(posedge clk);
    #1;
    ce = 1'b0;
    i_reg_wr = 1'b1;
    i_reg_data = 8'h44;
    @(posedge clk);
    #1;
    i_reg_wr = 1'b0;
    @(negedge clk);
    checkOutput("wr_without_ce", int'(o_busy), 0);

    $display("[TB] transfer $02, halt on put phase");
    runTransfer(8'h02, 1, 0, 1);
    $display("[TB] transfer $02, halt on get phase");
    runTransfer(8'h02, 0, 0, 1);
    $display("[TB] transfer $11 with three non-read cycles in halt");
    runTransfer(8'h11, -1, 3, 1);

    $display("[TB] transfer $FF with ce every third clock");
    base = loadCnt;
    runTransfer(8'hFF, -1, 0, 3);
    checkOutput("ff_load_count", loadCnt - base, 256);
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (oam[(base + i) % 256] !== mem[{8'hFF, 8'(i)}]) bad++;
    checkOutput("ff_oam_contents", bad, 0);

    $display("[TB] transfer $07 with a second write mid-transfer");
    cePeriod = 1;
    base = loadCnt;
    issueWrite(8'h07, -1, 0, 1);
    waitLoads(base, 100);
    issueWrite(8'h05, -1, 0, 0);
    waitDone(700);

    $display("[TB] reset during transfer of $09");
    base = loadCnt;
    issueWrite(8'h09, -1, 0, 1);
    waitLoads(base, 37);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset_halt", int'(o_cpu_halt), 0);
    checkOutput("midreset_busy", int'(o_busy), 0);
    checkOutput("midreset_load", int'(o_oam_load), 0);
    expAddr.delete();
    expData.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    runTransfer(8'h03, -1, 0, 1);

    $display("[TB] randomized transfers");
    for (int t = 0; t < 3; t++) begin
      runTransfer(8'($urandom), -1, int'($urandom_range(0, 4)), int'($urandom_range(1, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
